wrapper_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one Wrapper compute engine between N_REQ requesters.
- Per grant: latches the winning requester's vi/ui operands and pulses the engine's w_start for one cycle.
- While the job runs, routes engine wr_req/out back to the granted requester; releases the engine on done.
- Sits between the operand producers (concat outputs, control FSMs) and the single Wrapper instance.

---
 rtl/wrapper_arbiter.sv | 86 ++++++++
 tb/tb_wrapper_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wrapper_arbiter.sv
// wrapper_arbiter: round-robin arbiter sequencing N_REQ requesters onto one Wrapper engine.
// Optional BUSY watchdog abort is enabled by defining WRAPPER_ARB_WATCHDOG_EN.
module wrapper_arbiter #(
   parameter int N_REQ   = 4,
   parameter int VI_W    = 16,
   parameter int UI_W    = 2,
   parameter int OUT_W   = 21,
   parameter int TIMEOUT = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*VI_W-1:0] vi_in,
   input  logic [N_REQ*UI_W-1:0] ui_in,
   output logic [N_REQ-1:0]      gnt,
   output logic [N_REQ-1:0]      ack,
   output logic [N_REQ-1:0]      res_valid,
   output logic [OUT_W-1:0]      res_data,
   output logic                  err,
   output logic                  busy,
   output logic                  eng_start,
   output logic [VI_W-1:0]       eng_vi,
   output logic [UI_W-1:0]       eng_ui,
   input  logic                  eng_done,
   input  logic                  eng_wr_req,
   input  logic [OUT_W-1:0]      eng_out
);
   localparam int IW = $clog2(N_REQ);
   typedef enum logic [1:0] {IDLE, START, BUSY, RELEASE} state_t;
   state_t state, state_nx;
   logic [IW-1:0] g, last_grant, win;
   logic [N_REQ-1:0] g_oh;
   logic timeout;
   // scan downward so the first set bit after last_grant is the final assignment
   always_comb begin
      win = last_grant;
      for (int i = N_REQ; i >= 1; i--)
         if (req[(int'(last_grant) + i) % N_REQ]) win = IW'((int'(last_grant) + i) % N_REQ);
   end
`ifdef WRAPPER_ARB_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   logic err_q;
   assign timeout = state == BUSY && cnt == CW'(TIMEOUT - 1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         cnt   <= state == BUSY ? cnt + 1'b1 : '0;
         err_q <= timeout && !eng_done;
      end
   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif
   always_comb begin
      state_nx = state == IDLE  ? (|req ? START : IDLE) :
                 state == START ? BUSY :
                 state == BUSY  ? (eng_done || timeout ? RELEASE : BUSY) : IDLE;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state      <= IDLE;
         g          <= '0;
         last_grant <= IW'(N_REQ - 1);
         eng_vi     <= '0;
         eng_ui     <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && |req) begin
            g      <= win;
            eng_vi <= vi_in[win*VI_W +: VI_W];
            eng_ui <= ui_in[win*UI_W +: UI_W];
         end
         if (state == RELEASE) last_grant <= g;
      end
   assign g_oh      = N_REQ'(1) << g;
   assign busy      = state != IDLE;
   assign gnt       = busy ? g_oh : '0;
   assign ack       = state == RELEASE ? g_oh : '0;
   assign eng_start = state == START;
   assign res_valid = state == BUSY && eng_wr_req ? g_oh : '0;
   assign res_data  = eng_out;
endmodule

// File: tb/tb_wrapper_arbiter.sv
// tb_wrapper_arbiter: directed vector table plus hand sequences for wrapper_arbiter.
module tb_wrapper_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] vi_in;
   logic [7:0]  ui_in;
   logic [3:0]  gnt, ack, res_valid;
   logic [20:0] res_data;
   logic        err, busy, eng_start;
   logic [15:0] eng_vi;
   logic [1:0]  eng_ui;
   logic        eng_done, eng_wr_req;
   logic [20:0] eng_out;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  req;
      logic        done, wr;
      logic [3:0]  gnt, ack, rv;
      logic        start, busy;
      logic [15:0] vi;
      logic [1:0]  ui;
   } vec_t;
   vec_t tbl [25];

   wrapper_arbiter #(.N_REQ(4), .VI_W(16), .UI_W(2), .OUT_W(21), .TIMEOUT(50)) dut (
      .clk(clk), .rst(rst), .req(req), .vi_in(vi_in), .ui_in(ui_in),
      .gnt(gnt), .ack(ack), .res_valid(res_valid), .res_data(res_data),
      .err(err), .busy(busy), .eng_start(eng_start), .eng_vi(eng_vi), .eng_ui(eng_ui),
      .eng_done(eng_done), .eng_wr_req(eng_wr_req), .eng_out(eng_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      req = '0;
      eng_done = 1'b0;
      eng_wr_req = 1'b0;
      eng_out = '0;
      vi_in = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      ui_in = {2'd3, 2'd2, 2'd1, 2'd0};
      step();
      step();
      rst = 1'b1;
   endtask

   function automatic vec_t v(input logic [3:0] r, input logic d, input logic w,
                              input logic [3:0] eg, input logic [3:0] ea, input logic [3:0] erv,
                              input logic es, input logic eb, input logic [15:0] evi, input logic [1:0] eui);
      vec_t t;
      t.req = r; t.done = d; t.wr = w; t.gnt = eg; t.ack = ea; t.rv = erv;
      t.start = es; t.busy = eb; t.vi = evi; t.ui = eui;
      return t;
   endfunction

   initial begin
      int n;
      int pulses;
      logic bad;
      tbl[0]  = v(4'hF, 0, 0, 4'h1, 4'h0, 4'h0, 1, 1, 16'hA000, 2'd0);
      tbl[1]  = v(4'hF, 0, 1, 4'h1, 4'h0, 4'h1, 0, 1, 16'hA000, 2'd0);
      tbl[2]  = v(4'hF, 1, 0, 4'h1, 4'h1, 4'h0, 0, 1, 16'hA000, 2'd0);
      tbl[3]  = v(4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 16'hA000, 2'd0);
      tbl[4]  = v(4'hF, 0, 0, 4'h2, 4'h0, 4'h0, 1, 1, 16'hA001, 2'd1);
      tbl[5]  = v(4'hF, 0, 1, 4'h2, 4'h0, 4'h2, 0, 1, 16'hA001, 2'd1);
      tbl[6]  = v(4'hF, 1, 0, 4'h2, 4'h2, 4'h0, 0, 1, 16'hA001, 2'd1);
      tbl[7]  = v(4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 16'hA001, 2'd1);
      tbl[8]  = v(4'hF, 0, 0, 4'h4, 4'h0, 4'h0, 1, 1, 16'hA002, 2'd2);
      tbl[9]  = v(4'hF, 0, 1, 4'h4, 4'h0, 4'h4, 0, 1, 16'hA002, 2'd2);
      tbl[10] = v(4'hF, 1, 0, 4'h4, 4'h4, 4'h0, 0, 1, 16'hA002, 2'd2);
      tbl[11] = v(4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 16'hA002, 2'd2);
      tbl[12] = v(4'hF, 0, 0, 4'h8, 4'h0, 4'h0, 1, 1, 16'hA003, 2'd3);
      tbl[13] = v(4'hF, 0, 1, 4'h8, 4'h0, 4'h8, 0, 1, 16'hA003, 2'd3);
      tbl[14] = v(4'hF, 1, 0, 4'h8, 4'h8, 4'h0, 0, 1, 16'hA003, 2'd3);
      tbl[15] = v(4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 16'hA003, 2'd3);
      tbl[16] = v(4'hF, 0, 0, 4'h1, 4'h0, 4'h0, 1, 1, 16'hA000, 2'd0);
      tbl[17] = v(4'hF, 0, 1, 4'h1, 4'h0, 4'h1, 0, 1, 16'hA000, 2'd0);
      tbl[18] = v(4'hF, 1, 0, 4'h1, 4'h1, 4'h0, 0, 1, 16'hA000, 2'd0);
      tbl[19] = v(4'hF, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 16'hA000, 2'd0);
      tbl[20] = v(4'h5, 0, 0, 4'h4, 4'h0, 4'h0, 1, 1, 16'hA002, 2'd2);
      tbl[21] = v(4'h5, 0, 1, 4'h4, 4'h0, 4'h4, 0, 1, 16'hA002, 2'd2);
      tbl[22] = v(4'h5, 1, 0, 4'h4, 4'h4, 4'h0, 0, 1, 16'hA002, 2'd2);
      tbl[23] = v(4'h5, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 16'hA002, 2'd2);
      tbl[24] = v(4'h5, 0, 0, 4'h1, 4'h0, 4'h0, 1, 1, 16'hA000, 2'd0);

      reset_dut();
      chk("reset_outputs", {gnt, ack, res_valid, eng_start, busy, err, eng_vi, eng_ui}, 64'h0);

      // single requester, engine done 20 cycles after start
      vi_in[15:0] = 16'hFFFF;
      ui_in[1:0] = 2'd0;
      req = 4'b0001;
      step();
      chk("single_grant", {gnt, eng_start, eng_vi, eng_ui}, {4'b0001, 1'b1, 16'hFFFF, 2'd0});
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ack != 0 || eng_start || !busy) bad = 1'b1;
      end
      chk("single_busy_quiet", {63'h0, bad}, 64'h0);
      eng_done = 1'b1;
      step();
      chk("single_ack", {gnt, ack, busy}, {4'b0001, 4'b0001, 1'b1});
      eng_done = 1'b0;
      req = 4'b0000;
      step();
      chk("single_idle", {gnt, ack, busy}, {4'b0000, 4'b0000, 1'b0});

      // round robin and partial-request table
      reset_dut();
      for (int i = 0; i < 25; i++) begin
         req = tbl[i].req;
         eng_done = tbl[i].done;
         eng_wr_req = tbl[i].wr;
         step();
         chk($sformatf("vec%0d", i), {gnt, ack, res_valid, eng_start, busy, err, eng_vi, eng_ui},
             {tbl[i].gnt, tbl[i].ack, tbl[i].rv, tbl[i].start, tbl[i].busy, 1'b0, tbl[i].vi, tbl[i].ui});
      end

      // result routing to requester 2
      reset_dut();
      req = 4'b0100;
      step();
      chk("route_grant", {gnt, eng_start}, {4'b0100, 1'b1});
      step();
      eng_out = 21'h1ABCD;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         eng_wr_req = (k != 1 && k != 4);
         #1;
         chk($sformatf("route_rv%0d", k), {res_valid, res_data}, {(eng_wr_req ? 4'b0100 : 4'b0000), 21'h1ABCD});
         if (res_valid != 0) pulses++;
         step();
      end
      chk("route_pulses", 64'(pulses), 64'd3);
      eng_wr_req = 1'b0;
      eng_done = 1'b1;
      step();
      chk("route_ack", {ack, res_valid}, {4'b0100, 4'b0000});
      eng_done = 1'b0;
      req = 4'b0000;
      step();

      // done while idle is ignored
      reset_dut();
      eng_done = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (busy || gnt != 0 || ack != 0) bad = 1'b1;
      end
      chk("idle_done_ignored", {63'h0, bad}, 64'h0);
      eng_done = 1'b0;
      req = 4'b0001;
      step();
      chk("idle_done_then_grant", {gnt, eng_start}, {4'b0001, 1'b1});

      // req dropped mid-job, then wr_req and done together
      reset_dut();
      req = 4'b0010;
      step();
      step();
      req = 4'b0000;
      step();
      step();
      chk("drop_still_busy", {gnt, busy}, {4'b0010, 1'b1});
      eng_wr_req = 1'b1;
      eng_done = 1'b1;
      #1;
      chk("same_cycle_rv", {60'h0, res_valid}, {60'h0, 4'b0010});
      step();
      eng_wr_req = 1'b0;
      eng_done = 1'b0;
      #1;
      chk("same_cycle_ack", {ack, res_valid}, {4'b0010, 4'b0000});
      step();
      chk("drop_idle", {gnt, ack, busy}, {4'b0000, 4'b0000, 1'b0});
      step();
      chk("drop_no_regrant", {gnt, busy}, {4'b0000, 1'b0});

      // asynchronous reset mid-BUSY
      reset_dut();
      req = 4'b0100;
      step();
      step();
      eng_wr_req = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset", {gnt, ack, res_valid, eng_start, busy, err, eng_vi, eng_ui}, 64'h0);
      eng_wr_req = 1'b0;
      req = 4'b0000;
      step();
      rst = 1'b1;
      req = 4'b0010;
      step();
      chk("post_reset_grant", {gnt, eng_start, eng_vi}, {4'b0010, 1'b1, 16'hA001});

`ifdef WRAPPER_ARB_WATCHDOG_EN
      reset_dut();
      req = 4'b0011;
      step();
      step();
      n = 0;
      while (!err && n < 60) begin
         step();
         n++;
      end
      chk("wd_cycles", 64'(n), 64'd50);
      chk("wd_ack", {ack, err}, {4'b0001, 1'b1});
      step();
      chk("wd_err_pulse", {err, busy}, {1'b0, 1'b0});
      step();
      chk("wd_next_grant", {60'h0, gnt}, {60'h0, 4'b0010});
`else
      n = 0;
      chk("err_tied_low", {63'h0, err}, 64'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
